playlist_sequencer: RTL and testbench
=====================================

PLAYLIST_SEQUENCER -- requirements
Module: playlist_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per note slot.
REQ-002 Parameter NUM_SONGS, default 4, number of songs; fixed at 4 in this revision.
REQ-003 Parameter NOTE_W, default 9, note index width.
REQ-004 Port clk, input, 1: single system clock.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port mode, input, 1: 1 = sequential, 0 = shuffle.
REQ-007 Port key_play, input, 1: raw play/pause key, asynchronous level.
REQ-008 Port key_next, input, 1: raw next-song key, asynchronous level.
REQ-009 Port key_prev, input, 1: raw previous-song key, asynchronous level.
REQ-010 Port rom_addr, output, 11: {song_idx, note_idx} address to the note ROM.
REQ-011 Port rom_data, input, 16: note frequency word; valid one cycle after rom_addr.
REQ-012 Port freq, output, 16: frequency to the tone generator; 0 = silence.
REQ-013 Port song_idx, output, 2: current song.
REQ-014 Port playing, output, 1: high in FETCH, LOAD and PLAY.
REQ-015 Port song_done, output, 1: one-cycle pulse when a song ends naturally.

Function
REQ-016 Each key SHALL pass through a 2-flop synchroniser and rising-edge detector; downstream logic sees a 1-cycle event per press.
REQ-017 FSM states SHALL be STOP, FETCH, LOAD, PLAY and PAUSE.
REQ-018 STOP: freq=0, note_idx held; play event -> FETCH.
REQ-019 FETCH: rom_addr presented for one cycle -> LOAD.
REQ-020 LOAD: rom_data captured into note_reg; tick_cnt=0 -> PLAY.
REQ-021 PLAY: freq=note_reg; tick_cnt increments each cycle.
REQ-022 PLAY, at tick_cnt==TICK_DIV-1: note_idx+1 -> FETCH (note-to-note latency TICK_DIV+2 cycles).
REQ-023 PLAY, at tick_cnt==TICK_DIV-1 with note_idx==SONG_LEN[song_idx]-1: note_idx=0, song advances per REQ-026, song_done pulses -> FETCH.
REQ-024 PLAY, on play event: -> PAUSE, freq=0, tick_cnt and note_idx held.
REQ-025 PAUSE, on play event: -> PLAY, resuming the same tick_cnt and note_reg.
REQ-026 Song advance, sequential: (song_idx+1) mod 4.
REQ-027 Song advance, shuffle: lfsr[1:0]; if that equals song_idx, use (song_idx+1) mod 4 instead.
REQ-028 Next event in any state: song advances, note_idx=0, tick_cnt=0; FETCH/LOAD/PLAY -> FETCH; STOP/PAUSE -> STOP.
REQ-029 Prev event: song_idx=(song_idx-1) mod 4 in both modes; otherwise same as next.
REQ-030 Next and prev in the same cycle SHALL both be ignored.
REQ-031 Play coincident with an accepted next or prev SHALL be ignored.
REQ-032 freq SHALL be registered: 0 in STOP, PAUSE, FETCH and LOAD on entry from STOP or PAUSE; otherwise note_reg.
REQ-033 freq SHALL hold the previous note during FETCH/LOAD between consecutive notes, so there are no audible gaps.
REQ-034 tick_cnt SHALL be sized $clog2(TICK_DIV).
REQ-035 note_idx arithmetic SHALL wrap only via REQ-023; it never exceeds SONG_LEN-1.

Reset
REQ-036 rst SHALL force state=STOP, song_idx=0, note_idx=0, tick_cnt=0, note_reg=0, freq=0, song_done=0, playing=0, lfsr=8'hA5 and key synchronisers=0, from any state, next clock edge.

Configuration
REQ-037 SHUFFLE_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every clock, and mode=0 selects REQ-027.
REQ-038 SHUFFLE_EN undefined: no LFSR is built, mode is ignored, and advance is always sequential.

Structure
REQ-039 Package playlist_pkg SHALL hold the FSM state enum, SONG_LEN table {416,384,176,320}, LFSR seed and polynomial taps.
REQ-040 Sub-module key_edge (synchroniser + rising-edge detector) SHALL be instantiated three times.

Verification (TICK_DIV=4)
REQ-041 Scenario: rst, then key_play press -> playing=1 within 4 cycles; rom_addr=0x000; freq=rom_data[0] from PLAY entry; rom_addr=0x001 after 6 cycles.
REQ-042 Scenario: song 2 at note 175, tick 3 -> song_done pulse; song_idx=3; rom_addr=0x600.
REQ-043 Scenario: PLAY, play press at tick 1, wait 20 cycles, press again -> freq=0 while paused; note advances exactly 3 cycles after resume.
REQ-044 Scenario: next and prev pressed in the same cycle -> song_idx and note_idx unchanged; a separate prev from song 0 -> song_idx=3.
REQ-045 Scenario: SHUFFLE_EN, mode=0, 32 next presses -> never the same song twice consecutively; without SHUFFLE_EN the sequence is 1,2,3,0,...
REQ-046 Scenario: rst asserted mid-PLAY -> all REQ-036 values on the next clock; playing=0.

Source files
------------

// File: rtl/playlist_pkg.sv
// Shared types and tables for the playlist sequencer.
// State enum, song length table and LFSR constants.
package playlist_pkg;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_PAUSE
  } state_t;

  // Element 0 is song 0.
  localparam logic [3:0][8:0] SONG_LEN = {
    9'd320, 9'd176, 9'd384, 9'd416
  };

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [8:0] song_last(
    input logic [1:0] s
  );
    return SONG_LEN[s] - 9'd1;
  endfunction

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] l
  );
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_edge.sv
// Key synchroniser and rising-edge detector.
// Two flops cross the clock domain, a third marks the edge.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_rise
);

  logic [2:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) r_sh <= '0;
    else     r_sh <= {r_sh[1:0], i_key};
  end

  assign o_rise = r_sh[1] & ~r_sh[2];

endmodule

// File: rtl/playlist_sequencer.sv
// Note-ROM playlist sequencer with play/pause/next/prev keys.
// Define SHUFFLE_EN to build the LFSR shuffle mode.
module playlist_sequencer
  import playlist_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int NUM_SONGS = 4,
  parameter int NOTE_W    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 key_play,
  input  logic                 key_next,
  input  logic                 key_prev,
  output logic [10:0]          rom_addr,
  input  logic [15:0]          rom_data,
  output logic [15:0]          freq,
  output logic [1:0]           song_idx,
  output logic                 playing,
  output logic                 song_done
);

  localparam int SONG_W = $clog2(NUM_SONGS);
  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_DIV - 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [SONG_W-1:0]   r_song;
  logic [SONG_W-1:0]   w_song_nx;
  logic [SONG_W-1:0]   w_adv;
  logic [NOTE_W-1:0]   r_note;
  logic [NOTE_W-1:0]   w_note_nx;
  logic [NOTE_W-1:0]   w_note_last;
  logic [TW-1:0]       r_tick;
  logic [TW-1:0]       w_tick_nx;
  logic [15:0]         r_note_reg;
  logic [15:0]         w_note_reg_nx;
  logic [15:0]         r_freq;
  logic [15:0]         w_freq_nx;
  logic                r_done;
  logic                w_done_nx;

  logic w_ev_play;
  logic w_ev_next;
  logic w_ev_prev;
  logic w_nx;
  logic w_pv;
  logic w_pl;

  key_edge u_play (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_play),
    .o_rise (w_ev_play)
  );

  key_edge u_next (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_next),
    .o_rise (w_ev_next)
  );

  key_edge u_prev (
    .clk    (clk),
    .rst    (rst),
    .i_key  (key_prev),
    .o_rise (w_ev_prev)
  );

  // Simultaneous next+prev cancel; play loses to a skip.
  assign w_nx = w_ev_next & ~w_ev_prev;
  assign w_pv = w_ev_prev & ~w_ev_next;
  assign w_pl = w_ev_play & ~w_nx & ~w_pv;

`ifdef SHUFFLE_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  always_comb begin
    w_adv = r_song + 1'b1;
    if (!mode && (r_lfsr[SONG_W-1:0] != r_song))
      w_adv = r_lfsr[SONG_W-1:0];
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_adv = r_song + 1'b1;
`endif

  assign w_note_last = NOTE_W'(song_last(r_song));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_STOP;
      r_song     <= '0;
      r_note     <= '0;
      r_tick     <= '0;
      r_note_reg <= '0;
      r_freq     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_song     <= w_song_nx;
      r_note     <= w_note_nx;
      r_tick     <= w_tick_nx;
      r_note_reg <= w_note_reg_nx;
      r_freq     <= w_freq_nx;
      r_done     <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_song_nx     = r_song;
    w_note_nx     = r_note;
    w_tick_nx     = r_tick;
    w_note_reg_nx = r_note_reg;
    w_freq_nx     = r_freq;
    w_done_nx     = 1'b0;
    if (w_nx || w_pv) begin
      w_song_nx = w_nx ? w_adv : r_song - 1'b1;
      w_note_nx = '0;
      w_tick_nx = '0;
      if (r_state == ST_STOP ||
          r_state == ST_PAUSE) begin
        w_state_nx = ST_STOP;
        w_freq_nx  = '0;
      end else begin
        w_state_nx = ST_FETCH;
      end
    end else begin
      unique case (r_state)
        ST_STOP: begin
          if (w_pl) w_state_nx = ST_FETCH;
        end
        ST_FETCH: begin
          w_state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          w_note_reg_nx = rom_data;
          w_freq_nx     = rom_data;
          w_tick_nx     = '0;
          w_state_nx    = ST_PLAY;
        end
        ST_PLAY: begin
          if (w_pl) begin
            w_state_nx = ST_PAUSE;
            w_freq_nx  = '0;
          end else if (r_tick == TICK_LAST) begin
            w_tick_nx  = '0;
            w_state_nx = ST_FETCH;
            if (r_note == w_note_last) begin
              w_note_nx = '0;
              w_song_nx = w_adv;
              w_done_nx = 1'b1;
            end else begin
              w_note_nx = r_note + 1'b1;
            end
          end else begin
            w_tick_nx = r_tick + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (w_pl) begin
            w_state_nx = ST_PLAY;
            w_freq_nx  = r_note_reg;
          end
        end
        default: w_state_nx = ST_STOP;
      endcase
    end
  end

  assign rom_addr  = {r_song, r_note};
  assign freq      = r_freq;
  assign song_idx  = r_song;
  assign song_done = r_done;
  assign playing   = (r_state == ST_FETCH) ||
                     (r_state == ST_LOAD)  ||
                     (r_state == ST_PLAY);

endmodule

// File: tb/tb_playlist_sequencer.sv
// Self-checking bench for playlist_sequencer (TICK_DIV=4).
// Note-slot model plus directed literal checks.
module tb_playlist_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        kp = 1'b0;
  logic        kn = 1'b0;
  logic        kv = 1'b0;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] freq;
  logic [1:0]  song_idx;
  logic        playing;
  logic        song_done;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  playlist_sequencer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key_play  (kp),
    .key_next  (kn),
    .key_prev  (kv),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .freq      (freq),
    .song_idx  (song_idx),
    .playing   (playing),
    .song_done (song_done)
  );

  function automatic logic [15:0] rom_fn(
    input logic [10:0] a
  );
    return {5'b10101, a};
  endfunction

  function automatic int slen(input int s);
    case (s)
      0:       return 416;
      1:       return 384;
      2:       return 176;
      default: return 320;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Model: status 0=stopped 1=running 2=paused;
  // m_ph is the position inside a TD+2 cycle note slot.
  int          m_stat;
  int          m_song;
  int          m_note;
  int          m_ph;
  logic [15:0] m_freq;
  logic [15:0] m_nreg;
  bit          m_done;
  bit [2:0]    hp;
  bit [2:0]    hn;
  bit [2:0]    hv;

  always @(posedge clk) begin : model
    int st, sg, nt, ph;
    logic [15:0] fq, nr;
    bit dn, en, ep, el, nx, pv, pl;
    st = m_stat; sg = m_song; nt = m_note;
    ph = m_ph; fq = m_freq; nr = m_nreg;
    dn = 1'b0;
    en = hn[1] & ~hn[2];
    ep = hv[1] & ~hv[2];
    el = hp[1] & ~hp[2];
    nx = en & !ep;
    pv = ep & !en;
    pl = el & !nx & !pv;
    if (rst) begin
      st = 0; sg = 0; nt = 0; ph = 0;
      fq = '0; nr = '0;
    end else if (nx || pv) begin
      sg = nx ? (sg + 1) % 4 : (sg + 3) % 4;
      nt = 0; ph = 0;
      if (st != 1) begin
        st = 0; fq = '0;
      end
    end else if (st == 0) begin
      if (pl) begin st = 1; ph = 0; end
    end else if (st == 2) begin
      if (pl) begin st = 1; fq = nr; end
    end else if (ph == 0) begin
      ph = 1;
    end else if (ph == 1) begin
      nr = rom_fn({sg[1:0], nt[8:0]});
      fq = nr;
      ph = 2;
    end else if (pl) begin
      st = 2; fq = '0;
    end else if (ph == TD + 1) begin
      ph = 0;
      if (nt == slen(sg) - 1) begin
        nt = 0; sg = (sg + 1) % 4; dn = 1'b1;
      end else begin
        nt++;
      end
    end else begin
      ph++;
    end
    m_stat <= st; m_song <= sg; m_note <= nt;
    m_ph <= ph; m_freq <= fq; m_nreg <= nr;
    m_done <= dn;
    hp <= rst ? 3'b0 : {hp[1:0], kp};
    hn <= rst ? 3'b0 : {hn[1:0], kn};
    hv <= rst ? 3'b0 : {hv[1:0], kv};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [10:0] ea;
      ea = {m_song[1:0], m_note[8:0]};
      n_tot++;
      if (rom_addr === ea && freq === m_freq &&
          song_idx === m_song[1:0] &&
          playing === (m_stat == 1) &&
          song_done === m_done)
        n_pass++;
      else
        $display("FAIL model t=%0t addr=%h/%h freq=%h/%h song=%0d/%0d play=%b/%b done=%b/%b",
          $time, rom_addr, ea, freq, m_freq,
          song_idx, m_song[1:0], playing,
          (m_stat == 1), song_done, m_done);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  nm, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit p,
                       input bit nxt,
                       input bit prv);
    kp = p; kn = nxt; kv = prv;
    cyc(2);
    kp = 1'b0; kn = 1'b0; kv = 1'b0;
    cyc(4);
  endtask

  initial begin
    int n;
    bit ok;
    logic [10:0] last;
    int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef SHUFFLE_EN
    logic [1:0] prev_s;
`endif
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_playing", playing, 0);
    chk("rst_freq", freq, 0);
    chk("rst_addr", rom_addr, 0);

    // start from stop
    kp = 1'b1; n = 0;
    while (!playing && n < 8) begin
      cyc(1); n++;
      if (n == 2) kp = 1'b0;
    end
    kp = 1'b0;
    chk("play_latency", (playing && n <= 4), 1);
    chk("fetch_addr0", rom_addr, 11'h000);
    cyc(1);
    chk("load_freq_silent", freq, 0);
    cyc(1);
    chk("play_freq0", freq, 16'hA800);
    cyc(3);
    chk("addr_before6", rom_addr, 11'h000);
    cyc(1);
    chk("addr_after6", rom_addr, 11'h001);
    chk("gapless_freq", freq, 16'hA800);

    // pause at tick 1 of note 1
    cyc(1);
    kp = 1'b1;
    cyc(2);
    kp = 1'b0;
    cyc(1);
    chk("paused_playing", playing, 0);
    chk("paused_freq", freq, 0);
    ok = 1'b1;
    repeat (20) begin
      cyc(1);
      if (freq !== 16'h0 || rom_addr !== 11'h001 ||
          playing !== 1'b0)
        ok = 1'b0;
    end
    chk("pause_hold", ok, 1);
    kp = 1'b1; n = 0;
    while (!playing && n < 8) begin
      cyc(1); n++;
      if (n == 2) kp = 1'b0;
    end
    kp = 1'b0;
    chk("resume_playing", playing, 1);
    chk("resume_freq", freq, 16'hA801);
    n = 0;
    while (rom_addr == 11'h001 && n < 10) begin
      cyc(1); n++;
    end
    chk("resume_to_next", n, 3);

    // next while playing, then reset mid-play
    press(0, 1, 0);
    chk("next_play_song", song_idx, 1);
    chk("next_play_run", playing, 1);
    cyc(9);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_playing", playing, 0);
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_song", song_idx, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_done", song_done, 0);

    // next+prev together, then prev wrap
    press(0, 1, 1);
    chk("both_song", song_idx, 0);
    chk("both_addr", rom_addr, 0);
    press(0, 0, 1);
    chk("prev_wrap", song_idx, 3);

    // sequential advance from song 3
`ifdef SHUFFLE_EN
    mode = 1'b1;
`else
    mode = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      press(0, 1, 0);
      chk("seq_next", song_idx, seq[i]);
    end

`ifdef SHUFFLE_EN
    chk_en = 1'b0;
    mode = 1'b0;
    prev_s = song_idx;
    for (int i = 0; i < 32; i++) begin
      press(0, 1, 0);
      chk("shuffle_norepeat",
          (song_idx != prev_s), 1);
      prev_s = song_idx;
    end
    mode = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
`endif

    // natural end of song 2
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    press(0, 1, 0);
    press(0, 1, 0);
    chk("song2_sel", song_idx, 2);
    press(1, 0, 0);
    n = 0;
    last = rom_addr;
    while (!song_done && n < 1200) begin
      last = rom_addr;
      cyc(1); n++;
    end
    chk("done_seen", song_done, 1);
    chk("done_last_addr", last, 11'h4AF);
    chk("done_song", song_idx, 3);
    chk("done_addr", rom_addr, 11'h600);
    cyc(1);
    chk("done_pulse_1cyc", song_done, 0);
    chk("done_still_play", playing, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
